fir_stream_ctrl: RTL and testbench
==================================

FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample width.
REQ-002 SHALL have parameter TAPS, default 8, meaning filter tap count.
REQ-003 SHALL have parameter PIPE_LAT, default 10, meaning filter advances from input sample to its output.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports s_valid in 1, s_data in DATA_W, s_last in 1, s_ready out 1: upstream sample stream.
REQ-007 SHALL have ports f_en out 1, f_din out DATA_W, f_dout in DATA_W: filter advance strobe, filter input, filter output.
REQ-008 SHALL have ports m_valid out 1, m_data out DATA_W, m_last out 1, m_ready in 1: downstream filtered stream.
REQ-009 SHALL have ports busy out 1 (state != IDLE) and sample_cnt out 16 (samples accepted in current frame).

Function
REQ-010 SHALL implement states IDLE, RUN and FLUSH.
REQ-011 IDLE->RUN on first accepted sample; RUN->FLUSH on an accepted sample with s_last=1; FLUSH->IDLE after PIPE_LAT flush advances.
REQ-012 SHALL drive s_ready = (state is IDLE or RUN) and (m_ready or not m_valid); s_ready SHALL be 0 in FLUSH.
REQ-013 A sample is accepted when s_valid and s_ready are both 1.
REQ-014 SHALL assert f_en combinationally on every accept and on every FLUSH cycle where (m_ready or not m_valid); otherwise f_en=0, freezing the filter.
REQ-015 SHALL drive f_din = s_data on accept and 0 on flush advances.
REQ-016 SHALL carry a valid tag and a last tag per advance through a PIPE_LAT-deep shift register clocked only when f_en=1; real samples tag valid=1, flush zeros valid=0.
REQ-017 m_valid SHALL equal the tail valid tag, m_last the tail last tag, and m_data SHALL equal f_dout unregistered.
REQ-018 Latency: with continuous flow and m_ready=1, a sample accepted in cycle k SHALL appear on m_data with m_valid=1 in cycle k+PIPE_LAT.
REQ-019 Back-pressure: while m_valid=1 and m_ready=0, m_data, m_valid, m_last and all tags SHALL hold.
REQ-020 Upstream gaps (s_valid=0 in RUN) SHALL freeze the pipe; no output is produced until further data or flush.
REQ-021 The flush counter SHALL count only flush advances and pause under back-pressure.
REQ-022 sample_cnt SHALL increment per accept, saturate at 16'hFFFF, and clear on the FLUSH->IDLE transition.
REQ-023 A single-sample frame (first accept carries s_last) SHALL go IDLE->FLUSH directly.

Reset
REQ-024 On rst=0, regardless of state or pending frame: state IDLE, all tags 0, flush counter 0, sample_cnt 0, m_valid 0, m_last 0, f_en 0, s_ready 0.
REQ-025 After release, s_ready SHALL rise in the first cycle; frames interrupted by reset are discarded.

Configuration
REQ-026 Macro FIR_STREAM_CTRL_TAIL_EN: when defined, the first TAPS-1 flush zeros SHALL carry valid=1 and the last of them last=1 (full convolution tail, frame output length N+TAPS-1); the real last sample carries last=0.
REQ-027 When undefined, all flush zeros carry valid=0 and m_last accompanies the output of the sample accepted with s_last (output length N).

Structure
REQ-028 Package fir_pkg SHALL hold DATA_W, TAPS and PIPE_LAT defaults and the state enumeration type.
REQ-029 The tag shift register SHALL be sub-module fir_tag_pipe (width 2, depth PIPE_LAT, enable input).

Verification
REQ-030 Reset mid-RUN after 5 samples -> next cycle m_valid=0, busy=0, sample_cnt=0, s_ready=1 after release.
REQ-031 Frame of 16 back-to-back samples 1..16, m_ready=1, macro undefined -> 16 outputs, first in cycle k+10, m_last with 16th, busy falls after 10 flush advances.
REQ-032 Same frame with TAIL_EN defined -> 23 valid outputs, m_last on the 23rd only.
REQ-033 m_ready held 0 for 4 cycles mid-frame -> f_en=0 and s_ready=0 those cycles, m_data stable, no sample lost or duplicated.
REQ-034 Single-sample frame value 32'h0000_0100 with s_last=1 -> IDLE->FLUSH, one output with m_valid=1 and m_last=1.
REQ-035 s_valid toggling every other cycle -> f_en asserted only on accepts, output sequence identical to the gap-free run.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared defaults and types for the FIR stream controller.
//   FIR_DATA_W    : default sample width
//   FIR_TAPS      : default filter tap count
//   FIR_PIPE_LAT  : default filter advances from input sample to its output
//   fir_state_e   : controller state enumeration (IDLE, RUN, FLUSH)
//   flush_len()   : number of flush advances per frame
// Optional feature macro: FIR_STREAM_CTRL_TAIL_EN (full convolution tail).
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_DATA_W   = 32;
   localparam int FIR_TAPS     = 8;
   localparam int FIR_PIPE_LAT = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fir_state_e;

   // PIPE_LAT zero advances drain every real sample out of the filter. With the
   // convolution tail enabled, the TAPS-1 tail zeros are themselves outputs, so
   // they need PIPE_LAT further advances each to reach the end of the pipe.
   function automatic int flush_len(input int pipe_lat, input int taps);
`ifdef FIR_STREAM_CTRL_TAIL_EN
      return pipe_lat + taps - 1;
`else
      return pipe_lat + 0 * taps;
`endif
   endfunction

endpackage

// File: rtl/fir_tag_pipe.sv
// -----------------------------------------------------------------------------
// fir_tag_pipe
// Enable-gated shift register that travels alongside the external filter so
// every filter advance carries its own sideband tags to the output.
//   clk  : clock
//   rst  : asynchronous active-low reset, clears every stage
//   en   : shift enable (one filter advance)
//   din  : tag entering stage 0
//   dout : tag at the last stage (DEPTH advances after entry)
// -----------------------------------------------------------------------------
module fir_tag_pipe #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_reg  [DEPTH];
   logic [WIDTH-1:0] stage_next [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_next[gi] = din;
         end else begin : g_body
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= stage_next[i];
         end
      end
   end

   assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/fir_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fir_stream_ctrl
// Streams framed samples through an external fixed-latency FIR filter, flushes
// the filter with zeros after each frame and re-attaches valid/last to the
// filter output.
//   clk, rst                   : clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready : upstream sample stream
//   f_en/f_din/f_dout          : filter advance strobe, filter input, output
//   m_valid/m_data/m_last/m_ready : downstream filtered stream
//   busy                       : controller not idle
//   sample_cnt                 : samples accepted in the current frame
// Optional feature macro: FIR_STREAM_CTRL_TAIL_EN -- the first TAPS-1 flush
// zeros are emitted as valid outputs (full convolution tail).
// -----------------------------------------------------------------------------
module fir_stream_ctrl
   import fir_pkg::*;
#(
   parameter int DATA_W   = FIR_DATA_W,
   parameter int TAPS     = FIR_TAPS,
   parameter int PIPE_LAT = FIR_PIPE_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              f_en,
   output logic [DATA_W-1:0] f_din,
   input  logic [DATA_W-1:0] f_dout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic [15:0]       sample_cnt
);

   localparam int FLUSH_LEN = flush_len(PIPE_LAT, TAPS);
   localparam int FCNT_W    = $clog2(FLUSH_LEN + 1);

   fir_state_e        state_reg, state_next;
   logic [FCNT_W-1:0] flush_cnt_reg, flush_cnt_next;
   logic [15:0]       sample_cnt_reg, sample_cnt_next;

   logic       flow_ok, run_phase, accept, flush_adv, flush_done;
   logic [1:0] tag_in, tag_out;   // bit 1 = last, bit 0 = valid

   // The pipe may only move when the sample at its tail can leave.
   assign flow_ok   = m_ready | ~m_valid;
   assign run_phase = (state_reg == IDLE) || (state_reg == RUN);

   // Gated by rst so the handshake and strobe stay low while reset is held.
   assign s_ready    = rst & run_phase & flow_ok;
   assign accept     = s_valid & s_ready;
   assign flush_adv  = rst & (state_reg == FLUSH) & flow_ok;
   assign flush_done = flush_adv && (flush_cnt_reg == FCNT_W'(FLUSH_LEN - 1));

   assign f_en  = accept | flush_adv;
   assign f_din = accept ? s_data : '0;

`ifdef FIR_STREAM_CTRL_TAIL_EN
   // Real samples never close the frame; the last tail zero does.
   always_comb begin
      tag_in = 2'b00;
      if (accept) begin
         tag_in = 2'b01;
      end else if (flush_adv) begin
         tag_in[0] = (int'(flush_cnt_reg) <  TAPS - 1);
         tag_in[1] = (int'(flush_cnt_reg) == TAPS - 2);
      end
   end
`else
   // Flush zeros only push data through and never reach the output as valid.
   always_comb begin
      tag_in = 2'b00;
      if (accept) begin
         tag_in = {s_last, 1'b1};
      end
   end
`endif

   always_comb begin
      state_next      = state_reg;
      flush_cnt_next  = flush_cnt_reg;
      sample_cnt_next = sample_cnt_reg;
      if (accept && (sample_cnt_reg != 16'hFFFF)) begin
         sample_cnt_next = sample_cnt_reg + 16'd1;
      end
      case (state_reg)
         IDLE, RUN: begin
            // A frame of one sample goes straight from IDLE to FLUSH.
            if (accept) begin
               state_next = s_last ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            if (flush_adv) begin
               if (flush_done) begin
                  state_next      = IDLE;
                  flush_cnt_next  = '0;
                  sample_cnt_next = '0;
               end else begin
                  flush_cnt_next = flush_cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         flush_cnt_reg  <= '0;
         sample_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         flush_cnt_reg  <= flush_cnt_next;
         sample_cnt_reg <= sample_cnt_next;
      end
   end

   fir_tag_pipe #(
      .WIDTH (2),
      .DEPTH (PIPE_LAT)
   ) u_tag_pipe (
      .clk  (clk),
      .rst  (rst),
      .en   (f_en),
      .din  (tag_in),
      .dout (tag_out)
   );

   assign m_valid    = tag_out[0];
   assign m_last     = tag_out[1];
   assign m_data     = f_dout;
   assign busy       = (state_reg != IDLE);
   assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_stream_ctrl
// Bench for fir_stream_ctrl with a behavioural FIR (coefficients 1..TAPS,
// latency PIPE_LAT advances) attached to the filter port. Expected outputs are
// the plain convolution of each frame. Honours FIR_STREAM_CTRL_TAIL_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_stream_ctrl;

   localparam int DW   = 32;
   localparam int TAPS = 8;
   localparam int LAT  = 10;
`ifdef FIR_STREAM_CTRL_TAIL_EN
   localparam int FLUSH_N = LAT + TAPS - 1;
   localparam int EXTRA   = TAPS - 1;
`else
   localparam int FLUSH_N = LAT;
   localparam int EXTRA   = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic          f_en;
   logic [DW-1:0] f_din;
   logic [DW-1:0] f_dout;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_ready = 1'b1;
   logic          busy;
   logic [15:0]   sample_cnt;

   always #5 clk = ~clk;

   fir_stream_ctrl #(.DATA_W(DW), .TAPS(TAPS), .PIPE_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .f_en       (f_en),
      .f_din      (f_din),
      .f_dout     (f_dout),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .busy       (busy),
      .sample_cnt (sample_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cycle    = 0;

   always @(posedge clk) cycle <= cycle + 1;

   // ---------------- behavioural filter on the f_* port ----------------
   logic          en_s = 1'b0;
   logic [DW-1:0] din_s = '0;
   logic [DW-1:0] hist [TAPS];
   logic [DW-1:0] res  [LAT];
   logic [DW-1:0] filt_y;

   always @(negedge clk) begin
      en_s  <= f_en;
      din_s <= f_din;
   end

   always_comb begin
      filt_y = din_s;
      for (int i = 1; i < TAPS; i++) filt_y = filt_y + DW'(i + 1) * hist[i-1];
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) hist[i] <= '0;
         for (int i = 0; i < LAT; i++)  res[i]  <= '0;
      end else if (en_s) begin
         hist[0] <= din_s;
         for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
         res[0] <= filt_y;
         for (int i = 1; i < LAT; i++)  res[i]  <= res[i-1];
      end
   end

   assign f_dout = res[LAT-1];

   // ---------------- output monitor: a beat leaves when the pipe moves ----
   logic [DW:0] got_q[$];

   always @(negedge clk) begin
      if (rst && m_valid && m_ready && f_en) begin
         got_q.push_back({m_last, m_data});
         $display("out #%0d data=%08h last=%0b cycle=%0d", got_q.size(), m_data, m_last, cycle);
      end
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] frame_x [64];

   function automatic logic [DW-1:0] ref_y(input int j, input int n);
      logic [DW-1:0] acc = '0;
      for (int i = 0; i < TAPS; i++) begin
         if ((j - i >= 0) && (j - i < n)) acc = acc + DW'(i + 1) * frame_x[j-i];
      end
      return acc;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   int drv_idx, drv_fen_err, drv_fen_cnt, first_acc, first_mv;

   task automatic drive_frame(input int n, input bit gaps);
      int  guard = 0;
      bit  phase = 1'b0;
      drv_idx = 0; drv_fen_err = 0; drv_fen_cnt = 0; first_acc = -1; first_mv = -1;
      while (drv_idx < n && guard < 1000) begin
         s_valid = gaps ? phase : 1'b1;
         phase   = ~phase;
         s_data  = frame_x[drv_idx];
         s_last  = (drv_idx == n - 1);
         @(negedge clk);
         if (f_en !== (s_valid && s_ready)) drv_fen_err++;
         if (f_en) drv_fen_cnt++;
         if (m_valid && first_mv < 0) first_mv = cycle;
         if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = cycle;
            drv_idx++;
         end
         @(posedge clk); #1;
         guard++;
      end
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
   endtask

   task automatic wait_idle(output int flushes, output bit timed_out);
      int guard = 0;
      flushes = 0;
      while (busy && guard < 500) begin
         @(negedge clk);
         if (busy && f_en && !s_ready) flushes++;
         @(posedge clk); #1;
         guard++;
      end
      timed_out = busy;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; s_valid = 1'b1; s_data = 32'h5; m_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
      n_checks++; if (f_en !== 1'b0) $display("FAIL rst_f_en: got %b want 0", f_en); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
      n_checks++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %b want 0", m_last); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (sample_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", sample_cnt); else n_pass++;
      @(posedge clk); #1;
      s_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", s_ready); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int fl; bit to; int exp_len; logic [DW:0] e;
      for (int i = 0; i < 16; i++) frame_x[i] = DW'(i + 1);
      got_q.delete();
      drive_frame(16, 1'b0);
      n_checks++; if (drv_idx !== 16) $display("FAIL b2b_accepts: got %0d want 16", drv_idx); else n_pass++;
      n_checks++; if (first_mv !== first_acc + LAT) $display("FAIL b2b_latency: got cycle %0d want %0d", first_mv, first_acc + LAT); else n_pass++;
      n_checks++; if (sample_cnt !== 16'd16) $display("FAIL b2b_cnt: got %0d want 16", sample_cnt); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else n_pass++;
      wait_idle(fl, to);
      n_checks++; if (to !== 1'b0) $display("FAIL b2b_timeout: busy still %b", busy); else n_pass++;
      n_checks++; if (fl !== FLUSH_N) $display("FAIL b2b_flushes: got %0d want %0d", fl, FLUSH_N); else n_pass++;
      n_checks++; if (sample_cnt !== 16'd0) $display("FAIL b2b_cnt_clear: got %0d want 0", sample_cnt); else n_pass++;
      exp_len = 16 + EXTRA;
      n_checks++; if (got_q.size() !== exp_len) $display("FAIL b2b_count: got %0d outputs want %0d", got_q.size(), exp_len); else n_pass++;
      for (int j = 0; j < exp_len && j < got_q.size(); j++) begin
         e = {1'(j == exp_len - 1), ref_y(j, 16)};
         n_checks++;
         if (got_q[j] !== e) $display("FAIL b2b_out[%0d]: got %09h want %09h", j, got_q[j], e); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
         @(negedge clk); @(posedge clk); #1;
      end
      s_valid = 1'b0;
      n_checks++; if (sample_cnt !== 16'd5) $display("FAIL mid_cnt_before: got %0d want 5", sample_cnt); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b0) $display("FAIL mid_m_valid: got %b want 0", m_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (sample_cnt !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", sample_cnt); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", s_ready); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int idx = 0; int guard = 0; bit stalled = 1'b0; int fl; bit to; int exp_len;
      logic [DW-1:0] held; logic [DW:0] e;
      for (int i = 0; i < 20; i++) frame_x[i] = $urandom;
      got_q.delete();
      while (idx < 20 && guard < 500) begin
         s_valid = 1'b1; s_data = frame_x[idx]; s_last = (idx == 19);
         if (!stalled && idx == 14) begin
            m_ready = 1'b0;
            @(negedge clk);
            held = m_data;
            for (int s = 0; s < 4; s++) begin
               if (s > 0) @(negedge clk);
               n_checks++; if (f_en !== 1'b0) $display("FAIL bp_f_en[%0d]: got %b want 0", s, f_en); else n_pass++;
               n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready[%0d]: got %b want 0", s, s_ready); else n_pass++;
               n_checks++; if (m_valid !== 1'b1) $display("FAIL bp_m_valid[%0d]: got %b want 1", s, m_valid); else n_pass++;
               n_checks++; if (m_data !== held) $display("FAIL bp_m_data[%0d]: got %08h want %08h", s, m_data, held); else n_pass++;
               @(posedge clk); #1;
            end
            m_ready = 1'b1; stalled = 1'b1;
         end else begin
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
         end
         guard++;
      end
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(fl, to);
      n_checks++; if (to !== 1'b0 || idx !== 20) $display("FAIL bp_done: accepted %0d busy %b want 20 and 0", idx, busy); else n_pass++;
      exp_len = 20 + EXTRA;
      n_checks++; if (got_q.size() !== exp_len) $display("FAIL bp_count: got %0d outputs want %0d", got_q.size(), exp_len); else n_pass++;
      for (int j = 0; j < exp_len && j < got_q.size(); j++) begin
         e = {1'(j == exp_len - 1), ref_y(j, 20)};
         n_checks++;
         if (got_q[j] !== e) $display("FAIL bp_out[%0d]: got %09h want %09h", j, got_q[j], e); else n_pass++;
      end
   endtask

   task automatic test_single();
      int fl; bit to; int exp_len; logic [DW:0] e;
      frame_x[0] = 32'h0000_0100;
      got_q.delete();
      s_valid = 1'b1; s_data = frame_x[0]; s_last = 1'b1;
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) $display("FAIL single_accept: got %b want 1", s_ready); else n_pass++;
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk);
      // RUN with an empty output would keep s_ready high; only FLUSH drops it.
      n_checks++; if (busy !== 1'b1 || s_ready !== 1'b0) $display("FAIL single_flush: got busy=%b s_ready=%b want 1/0", busy, s_ready); else n_pass++;
      @(posedge clk); #1;
      wait_idle(fl, to);
      n_checks++; if (to !== 1'b0) $display("FAIL single_timeout: busy still %b", busy); else n_pass++;
      exp_len = 1 + EXTRA;
      n_checks++; if (got_q.size() !== exp_len) $display("FAIL single_count: got %0d outputs want %0d", got_q.size(), exp_len); else n_pass++;
      for (int j = 0; j < exp_len && j < got_q.size(); j++) begin
         e = {1'(j == exp_len - 1), ref_y(j, 1)};
         n_checks++;
         if (got_q[j] !== e) $display("FAIL single_out[%0d]: got %09h want %09h", j, got_q[j], e); else n_pass++;
      end
   endtask

   task automatic test_gaps();
      int fl; bit to; int exp_len; logic [DW:0] e;
      for (int i = 0; i < 16; i++) frame_x[i] = $urandom;
      got_q.delete();
      drive_frame(16, 1'b1);
      n_checks++; if (drv_idx !== 16) $display("FAIL gap_accepts: got %0d want 16", drv_idx); else n_pass++;
      n_checks++; if (drv_fen_err !== 0) $display("FAIL gap_f_en: %0d cycles with f_en != accept, want 0", drv_fen_err); else n_pass++;
      n_checks++; if (drv_fen_cnt !== 16) $display("FAIL gap_f_en_cnt: got %0d want 16", drv_fen_cnt); else n_pass++;
      n_checks++; if (sample_cnt !== 16'd16) $display("FAIL gap_cnt: got %0d want 16", sample_cnt); else n_pass++;
      wait_idle(fl, to);
      n_checks++; if (to !== 1'b0 || fl !== FLUSH_N) $display("FAIL gap_flush: got %0d flushes busy %b want %0d and 0", fl, busy, FLUSH_N); else n_pass++;
      exp_len = 16 + EXTRA;
      n_checks++; if (got_q.size() !== exp_len) $display("FAIL gap_count: got %0d outputs want %0d", got_q.size(), exp_len); else n_pass++;
      for (int j = 0; j < exp_len && j < got_q.size(); j++) begin
         e = {1'(j == exp_len - 1), ref_y(j, 16)};
         n_checks++;
         if (got_q[j] !== e) $display("FAIL gap_out[%0d]: got %09h want %09h", j, got_q[j], e); else n_pass++;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_reset_mid();
      test_backpressure();
      test_single();
      test_gaps();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
